// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: serialises byte/half/word load-store requests into byte-wide memory cycles,
// little-endian, returning extended load data or a store completion pulse.
module mem_access_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, ERR, RESP} state_t;
  state_t      r_state;
  logic [1:0]  r_size, r_last, r_cnt, r_pidx;
  logic        r_signed, r_pend;
  logic [31:0] r_wd, r_buf, w_buf, w_ext;
  logic        w_err;
  assign req_ready = r_state == IDLE;
  assign w_err = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  // the last read byte arrives on the same edge that forms the response, so merge it here
  always_comb begin
    w_buf = r_buf;
    if (r_pend) w_buf[8*r_pidx +: 8] = mem_rdata;
    w_ext = r_size == 2'b00 ? {{24{r_signed & w_buf[7]}}, w_buf[7:0]} :
            r_size == 2'b01 ? {{16{r_signed & w_buf[15]}}, w_buf[15:0]} : w_buf;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_size     <= 2'b00;
      r_last     <= 2'b00;
      r_cnt      <= 2'b00;
      r_pidx     <= 2'b00;
      r_signed   <= 1'b0;
      r_pend     <= 1'b0;
      r_wd       <= '0;
      r_buf      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      r_pend <= mem_en && !mem_we;
      r_pidx <= r_cnt;
      if (r_pend) r_buf[8*r_pidx +: 8] <= mem_rdata;
      case (r_state)
        IDLE: if (req_valid) begin
          r_size   <= req_size;
          r_signed <= req_signed;
          r_last   <= req_size == 2'b00 ? 2'd0 : req_size == 2'b01 ? 2'd1 : 2'd3;
          r_cnt    <= 2'd0;
          if (w_err) begin
            r_state    <= ERR;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            r_state   <= req_we ? WRITE : READ;
            mem_en    <= 1'b1;
            mem_we    <= req_we;
            mem_addr  <= req_addr;
            mem_wdata <= req_we ? req_wdata[7:0] : 8'd0;
            r_wd      <= req_wdata >> 8;
            r_buf     <= '0;
          end
        end
        WRITE, READ: if (r_cnt == r_last) begin
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_wdata <= 8'd0;
          r_state   <= r_state == WRITE ? RESP : DRAIN;
          if (r_state == WRITE) begin
            resp_valid <= 1'b1;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end else begin
          r_cnt     <= r_cnt + 2'd1;
          mem_addr  <= mem_addr + 1'b1;
          mem_wdata <= r_state == WRITE ? r_wd[7:0] : 8'd0;
          r_wd      <= r_wd >> 8;
        end
        DRAIN: begin
          r_state    <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= w_ext;
          resp_err   <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of mem_access_ctrl against a 1-cycle-latency byte memory model.
module tb_mem_access_ctrl;
  logic        clk = 0, rst_n = 0;
  logic        req_valid = 0, req_ready, req_we = 0, req_signed = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        resp_valid, resp_err, mem_en, mem_we;
  logic [31:0] resp_rdata, mem_addr;
  logic [7:0]  mem_wdata, mem_rdata = 0;
  logic [7:0]  mem [int unsigned];
  int          n_tests = 0, n_fail = 0, wr_total = 0;
  int          got_cyc, n_en, n_wr, first_en, last_en;
  logic [31:0] got_data, wr_addr [4];
  logic [7:0]  wr_data [4];
  logic        got_err;

  mem_access_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
    if (mem_en && mem_we) begin
      mem[mem_addr] = mem_wdata;
      wr_total++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // called at a negedge while idle; returns on the negedge of the cycle after the response
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd; req_valid = 1;
    got_cyc = 0; got_data = 0; got_err = 0; n_en = 0; n_wr = 0; first_en = 0; last_en = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      req_valid = 0;
      if (mem_en) begin
        n_en++;
        if (first_en == 0) first_en = c;
        last_en = c;
        if (mem_we && n_wr < 4) begin
          wr_addr[n_wr] = mem_addr;
          wr_data[n_wr] = mem_wdata;
          n_wr++;
        end
      end
      if (resp_valid) begin
        got_cyc = c; got_data = resp_rdata; got_err = resp_err;
        break;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int wr0;
    logic rv;
    logic [9:0] mask;
    logic rdy3;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {27'd0, mem_en, mem_we, resp_valid, resp_err, req_ready}, 32'h1);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", {mem_wdata, resp_rdata[23:0]}, 0);
    rst_n = 1;
    @(negedge clk);

    do_req(1, 2'b10, 0, 32'h1000, 32'hDEADBEEF);
    chk("sw_cyc", got_cyc, 5);
    chk("sw_err_rdata", {got_err, got_data[30:0]}, 0);
    chk("sw_en_span", {n_en[7:0], first_en[7:0], last_en[7:0]}, 32'h040104);
    chk("sw_nwr", n_wr, 4);
    chk("sw_bytes", {wr_data[3], wr_data[2], wr_data[1], wr_data[0]}, 32'hDEADBEEF);
    chk("sw_addr0", wr_addr[0], 32'h1000);
    chk("sw_addr3", wr_addr[3], 32'h1003);

    do_req(0, 2'b10, 0, 32'h1000, 0);
    chk("lw_cyc", got_cyc, 6);
    chk("lw_data", got_data, 32'hDEADBEEF);
    chk("lw_en", {n_en[15:0], n_wr[15:0]}, 32'h00040000);

    do_req(0, 2'b00, 1, 32'h1003, 0);
    chk("lb_cyc", got_cyc, 3);
    chk("lb_data", got_data, 32'hFFFFFFDE);
    do_req(0, 2'b00, 0, 32'h1003, 0);
    chk("lbu_data", got_data, 32'h000000DE);
    do_req(0, 2'b01, 1, 32'h1002, 0);
    chk("lh_cyc", got_cyc, 4);
    chk("lh_data", got_data, 32'hFFFFDEAD);
    do_req(0, 2'b01, 0, 32'h1000, 0);
    chk("lhu_data", got_data, 32'h0000BEEF);
    do_req(0, 2'b01, 1, 32'h1000, 0);
    chk("lh_neg", got_data, 32'hFFFFBEEF);
    do_req(0, 2'b10, 1, 32'h1000, 0);
    chk("lw_sign_ignored", got_data, 32'hDEADBEEF);

    do_req(1, 2'b00, 0, 32'h2001, 32'h123456AB);
    chk("sb_cyc", got_cyc, 2);
    chk("sb_nwr", n_wr, 1);
    chk("sb_byte", {wr_addr[0][23:0], wr_data[0]}, 32'h002001AB);
    do_req(0, 2'b10, 0, 32'h2000, 0);
    chk("sb_only_one", got_data, 32'h0000AB00);

    do_req(0, 2'b10, 0, 32'h1002, 0);
    chk("err_lw", {got_cyc[7:0], 7'd0, got_err, n_en[15:0]}, 32'h01010000);
    chk("err_lw_rdata", got_data, 0);
    do_req(1, 2'b01, 0, 32'h1001, 32'hFFFF);
    chk("err_sh", {got_cyc[7:0], 7'd0, got_err, n_en[15:0]}, 32'h01010000);
    do_req(0, 2'b11, 0, 32'h1000, 0);
    chk("err_size", {got_cyc[7:0], 7'd0, got_err, n_en[15:0]}, 32'h01010000);
    chk("err_size_rdata", got_data, 0);

    wr0 = wr_total;
    req_we = 1; req_size = 2'b10; req_signed = 0; req_addr = 32'h3000; req_wdata = 32'h11223344;
    req_valid = 1;
    @(negedge clk);
    req_valid = 0;
    chk("rst_mid_b0", {mem_en, mem_we, 6'd0, mem_addr[15:0], mem_wdata}, 32'hC0300044);
    rst_n = 0;
    rv = 0;
    repeat (2) begin
      @(negedge clk);
      rv |= resp_valid | mem_en;
    end
    rst_n = 1;
    chk("rst_mid_quiet", {31'd0, rv}, 0);
    chk("rst_mid_outs", {26'd0, mem_en, mem_we, resp_valid, resp_err, req_ready, |mem_wdata}, 32'h2);
    chk("rst_mid_nwr", wr_total - wr0, 1);
    @(negedge clk);
    do_req(0, 2'b10, 0, 32'h3000, 0);
    chk("rst_mid_mem", got_data, 32'h00000044);

    wr0 = wr_total;
    mask = 0; rdy3 = 0;
    req_we = 1; req_size = 2'b00; req_addr = 32'h4000; req_wdata = 32'h55; req_valid = 1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      mask[c] = resp_valid;
      if (c == 3) rdy3 = req_ready;
    end
    req_valid = 0;
    chk("b2b_resp_mask", {22'd0, mask}, 32'h124);
    chk("b2b_ready", {31'd0, rdy3}, 1);
    chk("b2b_nwr", wr_total - wr0, 3);
    repeat (4) @(negedge clk);
    chk("b2b_idle", {30'd0, req_ready, mem_en}, 32'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
